// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM.
//   - state_e   : FSM state encoding (BRANCH exists only when MC_BEQ_EN is defined)
//   - opcode_e  : supported IR[31:26] opcodes
//   - alu_op_e  : ALU_op encoding, shared with the downstream ALU control decoder
//   - src_b_e   : ALU_src_B encoding
//   - pc_src_e  : PC_source encoding
//   - ctrl_t    : bundle of all datapath strobes
//   - op_legal(): opcode support check used in DECODE
// Configuration macro: MC_BEQ_EN (enables beq / BRANCH state).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAddr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StRWb,
    StExecI,
    StIWb
`ifdef MC_BEQ_EN
    ,
    StBranch
`endif
  } state_e;

  typedef enum logic [5:0] {
    OpRtype = 6'b000000,
    OpBeq   = 6'b000100,
    OpAddi  = 6'b001000,
    OpOri   = 6'b001101,
    OpLw    = 6'b100011,
    OpSw    = 6'b101011
  } opcode_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10,
    AluOpOr    = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SrcBReg    = 2'b00,
    SrcBFour   = 2'b01,
    SrcBImm    = 2'b10,
    SrcBImmSh2 = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    PcSrcAlu    = 2'b00,
    PcSrcAluOut = 2'b01
  } pc_src_e;

  typedef struct packed {
    logic    pc_write;
    logic    pc_write_cond;
    logic    iord;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    mem_to_reg;
    logic    reg_dst;
    logic    reg_write;
    logic    alu_src_a;
    src_b_e  alu_src_b;
    alu_op_e alu_op;
    pc_src_e pc_source;
    logic    zero_ext;
    logic    illegal_op;
  } ctrl_t;

  function automatic logic op_legal(logic [5:0] op);
    logic legal;
    case (op)
      OpRtype, OpAddi, OpOri, OpLw, OpSw: legal = 1'b1;
`ifdef MC_BEQ_EN
      OpBeq: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational output decode for the multi-cycle control FSM.
// Ports:
//   rst_i       : synchronous reset level; forces every strobe low while high
//   state_i     : current FSM state
//   op_i        : opcode IR[31:26]
//   mem_ready_i : memory handshake, qualifies IR/PC load in FETCH
//   ctrl_o      : all datapath strobes
// Configuration macro: MC_BEQ_EN (decodes the BRANCH state).
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic       rst_i,
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    // Gate on reset so a state left over from before reset can't leak a write strobe.
    if (!rst_i) begin
      case (state_i)
        StFetch: begin
          ctrl_o.mem_read  = 1'b1;
          ctrl_o.alu_src_b = SrcBFour;
          ctrl_o.alu_op    = AluOpAdd;
          ctrl_o.ir_write  = mem_ready_i;
          ctrl_o.pc_write  = mem_ready_i;
        end
        StDecode: begin
          // ALU precomputes PC + (imm << 2) for a possible branch.
          ctrl_o.alu_src_b  = SrcBImmSh2;
          ctrl_o.alu_op     = AluOpAdd;
          ctrl_o.illegal_op = !op_legal(op_i);
        end
        StMemAddr: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SrcBImm;
          ctrl_o.alu_op    = AluOpAdd;
        end
        StMemRead: begin
          ctrl_o.mem_read = 1'b1;
          ctrl_o.iord     = 1'b1;
        end
        StMemWb: begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.mem_to_reg = 1'b1;
        end
        StMemWrite: begin
          ctrl_o.mem_write = 1'b1;
          ctrl_o.iord      = 1'b1;
        end
        StExecR: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SrcBReg;
          ctrl_o.alu_op    = AluOpFunct;
        end
        StRWb: begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.reg_dst   = 1'b1;
        end
        StExecI: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SrcBImm;
          if (op_i == OpOri) begin
            ctrl_o.alu_op   = AluOpOr;
            ctrl_o.zero_ext = 1'b1;
          end else begin
            ctrl_o.alu_op = AluOpAdd;
          end
        end
        StIWb: begin
          ctrl_o.reg_write = 1'b1;
        end
`ifdef MC_BEQ_EN
        StBranch: begin
          ctrl_o.alu_src_a     = 1'b1;
          ctrl_o.alu_src_b     = SrcBReg;
          ctrl_o.alu_op        = AluOpSub;
          ctrl_o.pc_write_cond = 1'b1;
          ctrl_o.pc_source     = PcSrcAluOut;
        end
`endif
        default: ctrl_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, stalls on Mem_ready and
// counts retired instructions.
// Ports:
//   clk, rst (sync, active-high), Op (IR[31:26]), Mem_ready
//   datapath strobes: PC_write, PC_write_cond, IorD, Mem_read, Mem_write, IR_write,
//   Mem_to_reg, Reg_dst, Reg_write, ALU_src_A, ALU_src_B, ALU_op, PC_source, Zero_ext
//   Illegal_op : one-cycle pulse in DECODE for an unsupported opcode
//   Retired    : wrapping count of completed instructions
// Configuration macro: MC_BEQ_EN (beq support; otherwise PC_write_cond/PC_source stay 0).
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic             Mem_ready,
  output logic             PC_write,
  output logic             PC_write_cond,
  output logic             IorD,
  output logic             Mem_read,
  output logic             Mem_write,
  output logic             IR_write,
  output logic             Mem_to_reg,
  output logic             Reg_dst,
  output logic             Reg_write,
  output logic             ALU_src_A,
  output logic [1:0]       ALU_src_B,
  output logic [1:0]       ALU_op,
  output logic [1:0]       PC_source,
  output logic             Zero_ext,
  output logic             Illegal_op,
  output logic [CNT_W-1:0] Retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  ctrl_t            ctrl;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch: if (Mem_ready) state_d = StDecode;
      StDecode: begin
        case (Op)
          OpLw, OpSw:     state_d = StMemAddr;
          OpRtype:        state_d = StExecR;
          OpAddi, OpOri:  state_d = StExecI;
`ifdef MC_BEQ_EN
          OpBeq:          state_d = StBranch;
`endif
          default:        state_d = StFetch;
        endcase
      end
      StMemAddr: state_d = (Op == OpLw) ? StMemRead : StMemWrite;
      StMemRead: if (Mem_ready) state_d = StMemWb;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWrite: begin
        if (Mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExecR: state_d = StRWb;
      StRWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StExecI: state_d = StIWb;
      StIWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
`ifdef MC_BEQ_EN
      StBranch: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
`endif
      default: state_d = StFetch;
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  mc_ctrl_decode u_decode (
    .rst_i       (rst),
    .state_i     (state_q),
    .op_i        (Op),
    .mem_ready_i (Mem_ready),
    .ctrl_o      (ctrl)
  );

  assign PC_write   = ctrl.pc_write;
  assign IorD       = ctrl.iord;
  assign Mem_read   = ctrl.mem_read;
  assign Mem_write  = ctrl.mem_write;
  assign IR_write   = ctrl.ir_write;
  assign Mem_to_reg = ctrl.mem_to_reg;
  assign Reg_dst    = ctrl.reg_dst;
  assign Reg_write  = ctrl.reg_write;
  assign ALU_src_A  = ctrl.alu_src_a;
  assign ALU_src_B  = ctrl.alu_src_b;
  assign ALU_op     = ctrl.alu_op;
  assign Zero_ext   = ctrl.zero_ext;
  assign Illegal_op = ctrl.illegal_op;
  // Without beq the decoder never drives these fields, so they are constant 0.
  assign PC_write_cond = ctrl.pc_write_cond;
  assign PC_source     = ctrl.pc_source;

  // Counter clears on the reset edge; mask it so the output reads 0 throughout reset.
  assign Retired = rst ? '0 : retired_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control
Main control FSM for the multi-cycle MIPS datapath, directly upstream of the ALU control decoder. It sequences fetch, decode, execute, memory and writeback for each instruction, and drives the datapath strobes and the 2-bit `ALU_op` that the ALU control decoder consumes. It also stalls on a memory-ready handshake and counts retired instructions.
## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Op` in 6: opcode field `IR[31:26]`; stable from `DECODE` until the next `FETCH`.
- `Mem_ready` in 1: memory completes the current access this cycle.
- `PC_write` out 1: unconditional PC load.
- `PC_write_cond` out 1: PC load qualified externally by ALU zero.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `Mem_read` out 1: memory read request.
- `Mem_write` out 1: memory write request.
- `IR_write` out 1: instruction register load.
- `Mem_to_reg` out 1: register-file write data select; 1 = MDR, 0 = ALUOut.
- `Reg_dst` out 1: destination select; 1 = rd, 0 = rt.
- `Reg_write` out 1: register-file write enable.
- `ALU_src_A` out 1: 0 = PC, 1 = register A.
- `ALU_src_B` out 2: 00 = register B, 01 = 4, 10 = extended immediate, 11 = sign-extended immediate shifted left by 2.
- `ALU_op` out 2: 00 = add, 01 = sub, 10 = R-type by funct, 11 = or.
- `PC_source` out 2: 00 = ALU result, 01 = ALUOut (branch target).
- `Zero_ext` out 1: immediate extender zero-extends instead of sign-extends.
- `Illegal_op` out 1: unsupported opcode seen in `DECODE`.
- `Retired` out `CNT_W`: count of completed instructions.
## Operation
- Opcodes:
  - R-type = 000000
  - addi = 001000
  - ori = 001101
  - lw = 100011
  - sw = 101011
  - beq = 000100 (macro-gated)
- Default value of every output is 0. Only the outputs listed per state are driven.
- `FETCH`: `Mem_read`=1, `ALU_src_B`=01, `ALU_op`=00.
  - `IR_write` and `PC_write` follow `Mem_ready`.
  - If `Mem_ready`=1, go to `DECODE`; otherwise stay in `FETCH`.
- `DECODE`: `ALU_src_B`=11, `ALU_op`=00 (precomputes the branch target).
  - lw or sw -> `MEM_ADDR`.
  - R-type -> `EXEC_R`.
  - addi or ori -> `EXEC_I`.
  - beq -> `BRANCH`.
  - Any other opcode -> `FETCH` with `Illegal_op`=1.
- `MEM_ADDR`: `ALU_src_A`=1, `ALU_src_B`=10, `ALU_op`=00. Go to `MEM_READ` for lw, `MEM_WRITE` for sw.
- `MEM_READ`: `Mem_read`=1, `IorD`=1. Wait for `Mem_ready`, then go to `MEM_WB`.
- `MEM_WB`: `Reg_write`=1, `Mem_to_reg`=1, `Reg_dst`=0. Go to `FETCH`.
- `MEM_WRITE`: `Mem_write`=1, `IorD`=1. Wait for `Mem_ready`, then go to `FETCH`.
- `EXEC_R`: `ALU_src_A`=1, `ALU_src_B`=00, `ALU_op`=10. Go to `R_WB`.
- `R_WB`: `Reg_write`=1, `Reg_dst`=1. Go to `FETCH`.
- `EXEC_I`: `ALU_src_A`=1, `ALU_src_B`=10.
  - addi: `ALU_op`=00.
  - ori: `ALU_op`=11 and `Zero_ext`=1.
  - Go to `I_WB`.
- `I_WB`: `Reg_write`=1, `Reg_dst`=0. Go to `FETCH`.
- `BRANCH`: `ALU_src_A`=1, `ALU_src_B`=00, `ALU_op`=01, `PC_write_cond`=1, `PC_source`=01. Go to `FETCH`.
- `Retired` increments by 1 on the edge that leaves `MEM_WB`, `MEM_WRITE` (with `Mem_ready`=1), `R_WB`, `I_WB` or `BRANCH`. It wraps from all-ones to 0. An illegal opcode does not increment it.
## Timing
- Outputs are Moore-style, decoded from the state register. The only exceptions are the `Op`-dependent fields in `EXEC_I` and `DECODE`, and the `Mem_ready`-qualified strobes in `FETCH`.
- Latency with `Mem_ready` held at 1:
  - R-type, addi, ori, sw: 4 cycles.
  - lw: 5 cycles.
  - beq: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle with `Mem_ready`=0 in `FETCH`, `MEM_READ` or `MEM_WRITE` adds exactly one cycle. All strobes stay held while waiting.
- Reset:
  - While `rst`=1, every output is 0, including all write and read strobes.
  - On the next edge, state is `FETCH` and `Retired` is 0.
  - Reset mid-instruction abandons that instruction; no pending write strobe appears.
- `Illegal_op` is a single-cycle pulse, coincident with the `DECODE` cycle.
## Configuration
- `MC_BEQ_EN` defined: beq decodes to `BRANCH` and `PC_write_cond`/`PC_source` are live.
- `MC_BEQ_EN` undefined:
  - opcode 000100 is illegal;
  - `BRANCH` is absent;
  - `PC_write_cond` is tied to 0;
  - `PC_source` is tied to 00.
## Structure
- Shared package `mc_ctrl_pkg` holds:
  - the state enum;
  - the opcode constants;
  - the `ALU_op` and `ALU_src_B` encodings (the ALU control decoder uses the same `ALU_op` encoding).
- One natural sub-module: `mc_ctrl_decode`, the combinational mapping from state and `Op` to outputs. The state register, next-state logic and counter stay in the top module.
## Test plan
- Hold `rst` for 2 cycles with `Mem_ready`=1 -> all outputs 0 during reset. First cycle after release: `Mem_read`=`IR_write`=`PC_write`=1, `ALU_src_B`=01.
- R-type `Op`=000000, `Mem_ready`=1 -> `ALU_op`=10 in cycle 3; `Reg_write`=`Reg_dst`=1 in cycle 4; `Retired` goes 0 -> 1.
- lw `Op`=100011 with `Mem_ready`=0 for 2 cycles in `MEM_READ` -> 7 cycles total; `Mem_read`=`IorD`=1 held throughout the wait; `Mem_to_reg`=`Reg_write`=1 in the last cycle.
- ori `Op`=001101 -> `EXEC_I` drives `ALU_op`=11, `Zero_ext`=1, `ALU_src_B`=10, followed by `I_WB` with `Reg_write`=1.
- `Op`=000100 with `MC_BEQ_EN` -> 3 cycles with `PC_write_cond`=1 and `ALU_op`=01. Without the macro -> `Illegal_op`=1 for one cycle, back to `FETCH`, `Retired` unchanged.
- sw, with `rst` asserted in the `MEM_ADDR` cycle -> `Mem_write` is never asserted; state is `FETCH` after release.
